// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: register file, hazard scoreboard and operand staging for the ALU.
// Issue requests are read with writeback bypass and presented as registered operands.
module alu_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [1:0]        in_op_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic [1:0]        out_op_code,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              ebusy_rs1;
    logic              ebusy_rs2;
    logic              ebusy_rd;
    logic              hazard;
    logic              accept;
    logic              issue_set;
    logic              wb_write;

    // Operand read with same-cycle writeback bypass, hazard detection and handshake.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (in_rs1 != '0) begin
            rs1_val = (wb_en && wb_addr == in_rs1) ? wb_data : regs[in_rs1];
        end
        if (in_rs2 != '0) begin
            rs2_val = (wb_en && wb_addr == in_rs2) ? wb_data : regs[in_rs2];
        end
        // A writeback landing this cycle releases the register immediately.
        ebusy_rs1 = (in_rs1 != '0) && busy[in_rs1] && !(wb_en && wb_addr == in_rs1);
        ebusy_rs2 = (in_rs2 != '0) && busy[in_rs2] && !(wb_en && wb_addr == in_rs2);
        ebusy_rd  = (in_rd  != '0) && busy[in_rd]  && !(wb_en && wb_addr == in_rd);
        hazard    = ebusy_rs1 | (!in_use_imm & ebusy_rs2) | (in_rd_we & ebusy_rd);
        in_ready  = rst_n & (!out_valid | out_ready) & !hazard;
        accept    = in_valid & in_ready;
        issue_set = accept & in_rd_we & (in_rd != '0);
        wb_write  = wb_en & (wb_addr != '0);
    end

    // Register file and in-flight scoreboard; an issue set overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            if (wb_write) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            if (issue_set) begin
                busy[in_rd] <= 1'b1;
            end
        end
    end

    // Output stage: load on accept, drop valid when consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_op_code <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_x       <= rs1_val;
            out_y       <= in_use_imm ? in_imm : rs2_val;
            out_op_code <= in_op_code;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we & (in_rd != '0);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
